demux_tdm_1to4: RTL and testbench
=================================

DEMUX_TDM_1TO4 -- requirements
Module: demux_tdm_1to4

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per time slot (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port din  input  1  serial TDM data bit, MSB of each slot first.
REQ-005 SHALL have port en  input  1  din/fsync qualifier; the bit is sampled only when en=1.
REQ-006 SHALL have port fsync  input  1  frame marker, high with bit 0 of slot 0.
REQ-007 SHALL have ports q0, q1, q2, q3  output  DATA_W each  last complete word of slots 0..3.
REQ-008 SHALL have port qv  output  4  one-cycle strobe per lane; qv[n] marks a new qn.
REQ-009 SHALL have port sel  output  2  slot currently being received.
REQ-010 SHALL have port locked  output  1  high while in RUN.
REQ-011 SHALL have port err  output  1  one-cycle framing-error strobe.

Function
REQ-012 SHALL implement states HUNT and RUN, with a bit counter (0..DATA_W-1) and a slot counter (0..3); a frame is 4*DATA_W qualified bits.
REQ-013 In HUNT, bits with en=1 and fsync=0 SHALL be discarded with no output change.
REQ-014 In HUNT, en=1 with fsync=1 SHALL take that bit as slot 0 bit 0 and move to RUN.
REQ-015 In RUN, each en=1 bit SHALL shift MSB-first into the lane deserializer selected by sel.
REQ-016 Cycles with en=0 SHALL hold all counters, shift registers and outputs; fsync SHALL be ignored when en=0.
REQ-017 On the edge sampling bit DATA_W-1 of slot n, qn SHALL load the complete word and qv[n] SHALL be high for exactly the following cycle (1-cycle latency).
REQ-018 At most one qv bit SHALL be high in any cycle; the other q outputs SHALL hold their values.
REQ-019 After bit DATA_W-1, the bit counter SHALL wrap to 0 and the slot counter SHALL advance; slot 3 SHALL wrap to slot 0.
REQ-020 At an expected frame start (slot 0, bit 0), fsync=1 SHALL continue RUN with no error.
REQ-021 At an expected frame start with fsync=0, err SHALL pulse, the bit SHALL be discarded and the state SHALL go to HUNT.
REQ-022 An fsync=1 bit at any non-frame-start position in RUN SHALL pulse err, discard the partial word (no qv), and restart at slot 0 bit 0 with that bit as its MSB, staying in RUN.
REQ-023 If REQ-022 coincides with a word-complete position, the resync SHALL take priority and that word SHALL NOT be emitted.
REQ-024 sel SHALL equal the slot counter in RUN and 0 in HUNT; locked SHALL equal (state==RUN).

Reset
REQ-025 Asserting rst SHALL immediately force: state HUNT, both counters 0, all shift registers 0, q0..q3 0, qv 0, sel 0, locked 0, err 0.
REQ-026 Reset asserted mid-frame SHALL drop any partial word without a qv pulse; after release, reception SHALL wait for a new fsync.

Structure
REQ-027 A shared package demux_tdm_pkg SHALL hold NUM_SLOTS=4, the slot-index width (2) and the state encoding (HUNT, RUN).
REQ-028 The per-lane serial-to-parallel register with word load SHALL be one sub-module, demux_lane, instantiated four times and controlled by the slot/bit counters and FSM in the top module.

Verification
REQ-029 With DATA_W=8, after reset send fsync at frame start and bytes A5,3C,FF,01 continuously (en=1) -> q0..q3=A5,3C,FF,01, qv pulses 1,2,4,8 on consecutive slot boundaries, err=0, locked=1.
REQ-030 Same frame with en toggling 1/0 every cycle -> identical q values, qv spacing doubled, no err.
REQ-031 Send two frames, second without fsync at its start -> err pulses once at frame start, locked drops, q values from frame 1 held, no qv pulses until the next fsync.
REQ-032 Assert fsync at slot 1 bit 3 -> err pulses, q1 unchanged, no qv[1]; the following 8 bits land in q0.
REQ-033 Assert rst in slot 2 bit 5 -> all outputs 0 immediately; after release, bits before fsync are ignored and reception restarts correctly at the next fsync.

Source files
------------

// File: rtl/demux_tdm_pkg.sv
// Shared constants and state encoding for the 1-to-4 TDM demultiplexer.
package demux_tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_lane.sv
// One output lane: serial-to-parallel shifter with a word register and a
// one-cycle valid strobe that follows each word load.
module demux_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              shift,
  input  logic              load,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  // Only DATA_W-1 bits need storing: the final bit comes straight from din.
  logic [DATA_W-2:0] sr;
  logic [DATA_W-1:0] next_word;

  assign next_word = {sr, din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (shift) sr <= next_word[DATA_W-2:0];
      if (load)  q  <= next_word;
    end
  end

endmodule

// File: rtl/demux_tdm_1to4.sv
// Serial TDM frame receiver: locks on fsync, steers each MSB-first slot into
// one of four lanes, and resynchronises or drops lock on framing errors.
module demux_tdm_1to4
  import demux_tdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              en,
  input  logic              fsync,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [3:0]        qv,
  output logic [1:0]        sel,
  output logic              locked,
  output logic              err
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SLOT_W-1:0]  slot_cnt;
  logic               err_r;
  logic               last_bit;
  logic               frame_start;
  logic [NUM_SLOTS-1:0] shift;
  logic [NUM_SLOTS-1:0] load;
  logic [NUM_SLOTS-1:0] valid;
  logic [DATA_W-1:0]  lane_q [NUM_SLOTS];

  assign last_bit    = (bit_cnt == CNT_W'(DATA_W - 1));
  assign frame_start = (slot_cnt == '0) && (bit_cnt == '0);

  // Lane steering. An fsync off the frame start restarts lane 0 and suppresses
  // any load, so a resync on a word-complete bit never emits that word.
  always_comb begin
    shift = '0;
    load  = '0;
    if (en) begin
      case (state)
        HUNT: if (fsync) shift[0] = 1'b1;
        RUN: begin
          if (fsync) begin
            shift[0] = 1'b1;
          end else if (!frame_start) begin
            shift[slot_cnt] = 1'b1;
            load[slot_cnt]  = last_bit;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      slot_cnt <= '0;
      err_r    <= 1'b0;
    end else begin
      err_r <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (fsync) begin
              state    <= RUN;
              bit_cnt  <= CNT_W'(1);
              slot_cnt <= '0;
            end
          end
          RUN: begin
            if (frame_start && !fsync) begin
              err_r <= 1'b1;
              state <= HUNT;
            end else if (!frame_start && fsync) begin
              err_r    <= 1'b1;
              bit_cnt  <= CNT_W'(1);
              slot_cnt <= '0;
            end else if (last_bit) begin
              bit_cnt  <= '0;
              slot_cnt <= slot_cnt + SLOT_W'(1);
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_lane
    demux_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .shift (shift[n]),
      .load  (load[n]),
      .q     (lane_q[n]),
      .valid (valid[n])
    );
  end

  // Counters return to zero whenever HUNT is entered, so sel needs no gating.
  assign q0     = lane_q[0];
  assign q1     = lane_q[1];
  assign q2     = lane_q[2];
  assign q3     = lane_q[3];
  assign qv     = valid;
  assign sel    = slot_cnt;
  assign locked = (state == RUN);
  assign err    = err_r;

endmodule

// File: tb/tb_demux_tdm_1to4.sv
// Directed bench for demux_tdm_1to4 (DATA_W=8): expected lane words are queued
// as frames are sent and popped by a monitor whenever qv strobes.
module tb_demux_tdm_1to4;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         din;
  logic         en;
  logic         fsync;
  logic [W-1:0] q0, q1, q2, q3;
  logic [3:0]   qv;
  logic [1:0]   sel;
  logic         locked;
  logic         err;

  logic [W+1:0] exp_q[$];
  int total;
  int bad;
  int err_seen;
  int err_base;

  demux_tdm_1to4 #(.DATA_W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .en     (en),
    .fsync  (fsync),
    .q0     (q0),
    .q1     (q1),
    .q2     (q2),
    .q3     (q3),
    .qv     (qv),
    .sel    (sel),
    .locked (locked),
    .err    (err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // monitor: pops one expected {lane, word} per qv strobe
  always @(negedge clk) begin
    logic [W+1:0] exp_v;
    logic [W+1:0] act_v;
    logic [1:0]   lane;
    if (err) err_seen++;
    if (qv != 4'b0000) begin
      total++;
      lane = qv[1] ? 2'd1 : qv[2] ? 2'd2 : qv[3] ? 2'd3 : 2'd0;
      case (lane)
        2'd0:    act_v = {lane, q0};
        2'd1:    act_v = {lane, q1};
        2'd2:    act_v = {lane, q2};
        default: act_v = {lane, q3};
      endcase
      if ($countones(qv) != 1) begin
        bad++;
        $display("FAIL qv_onehot: got qv=%b want exactly one bit", qv);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL qv_unexpected: got lane %0d word %h want no strobe", lane, act_v[W-1:0]);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v)
          begin
            bad++;
            $display("FAIL lane_word: got lane %0d word %h want lane %0d word %h",
                     act_v[W+1:W], act_v[W-1:0], exp_v[W+1:W], exp_v[W-1:0]);
          end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick(input logic e, input logic d, input logic f);
    en = e; din = d; fsync = f;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic fs, input logic tog);
    for (int i = W - 1; i >= 0; i--) begin
      tick(1'b1, w[i], fs && (i == W - 1));
      if (tog) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input logic [31:0] f, input logic fs, input logic tog, input logic expect_out);
    for (int s = 0; s < 4; s++) begin
      logic [W-1:0] w;
      w = f[31 - 8*s -: 8];
      if (expect_out) exp_q.push_back({2'(s), w});
      send_word(w, fs && (s == 0), tog);
    end
  endtask

  task automatic do_reset();
    en = 1'b0; din = 1'b0; fsync = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    err_base = err_seen;
  endtask

  task automatic check_q(input string name, input logic [31:0] exp);
    check(name, {q0, q1, q2, q3}, exp);
  endtask

  initial begin
    total = 0; bad = 0; err_seen = 0; err_base = 0;
    en = 1'b0; din = 1'b0; fsync = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_q", {q0, q1, q2, q3}, 32'h0);
    check("reset_ctl", {24'h0, qv, sel, locked, err}, 32'h0);
    do_reset();

    // continuous frame
    exp_q.push_back({2'd0, 8'hA5});
    send_word(8'hA5, 1'b1, 1'b0);
    check("sel_after_slot0", 32'(sel), 32'd1);
    send_word(8'h3C, 1'b0, 1'b0);
    exp_q.push_back({2'd1, 8'h3C});
    send_word(8'hFF, 1'b0, 1'b0);
    exp_q.push_back({2'd2, 8'hFF});
    send_word(8'h01, 1'b0, 1'b0);
    exp_q.push_back({2'd3, 8'h01});
    idle(2);
    check_q("cont_q", 32'hA53CFF01);
    check("cont_locked", 32'(locked), 32'd1);
    check("cont_err", 32'(err_seen - err_base), 32'd0);

    // same frame with en toggling; fsync/din noise on en=0 cycles
    do_reset();
    send_frame(32'hA53CFF01, 1'b1, 1'b1, 1'b1);
    idle(2);
    check_q("tog_q", 32'hA53CFF01);
    check("tog_err", 32'(err_seen - err_base), 32'd0);

    // missing fsync on second frame
    do_reset();
    send_frame(32'h11223344, 1'b1, 1'b0, 1'b1);
    send_frame(32'h55667788, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("nofs_err", 32'(err_seen - err_base), 32'd1);
    check("nofs_locked", 32'(locked), 32'd0);
    check_q("nofs_hold", 32'h11223344);
    send_frame(32'h99AABBCC, 1'b1, 1'b0, 1'b1);
    idle(2);
    check_q("relock_q", 32'h99AABBCC);
    check("relock_locked", 32'(locked), 32'd1);

    // fsync at slot 1 bit 3 resyncs into lane 0
    do_reset();
    exp_q.push_back({2'd0, 8'h5A});
    send_word(8'h5A, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    exp_q.push_back({2'd0, 8'hC3});
    send_word(8'hC3, 1'b1, 1'b0);
    idle(2);
    check("resync_err", 32'(err_seen - err_base), 32'd1);
    check_q("resync_q", 32'hC3000000);
    check("resync_sel", 32'(sel), 32'd1);
    check("resync_locked", 32'(locked), 32'd1);

    // reset in slot 2 bit 5
    do_reset();
    exp_q.push_back({2'd0, 8'h12});
    send_word(8'h12, 1'b1, 1'b0);
    exp_q.push_back({2'd1, 8'h34});
    send_word(8'h34, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_q", {q0, q1, q2, q3}, 32'h0);
    check("midrst_ctl", {24'h0, qv, sel, locked, err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    err_base = err_seen;
    send_word(8'hFF, 1'b0, 1'b0);
    check("hunt_locked", 32'(locked), 32'd0);
    send_frame(32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
    idle(3);
    check_q("postrst_q", 32'hDEADBEEF);
    check("postrst_err", 32'(err_seen - err_base), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
